// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the framed serial transmitter.
// Line levels, FSM states and the counter width helper live here.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_period_timer.sv
// Bit period timer: counts 0..CLKS_PER_BIT-1 while enabled and
// pulses bit_tick on the terminal count; held at zero when idle.
module bit_period_timer
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bit_tick
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || bit_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: one-word holding buffer feeding a
// start/data/stop serialiser with a programmable bit period.
module serial_frame_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ser_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int IW = cnt_w(DATA_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              ser_out_q, ser_out_d;
  logic              frame_done_q, frame_done_d;
  logic              bit_tick;
  logic              accept;
  logic              load;

  function automatic logic head(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_next(
    input logic [DATA_W-1:0] w
  );
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0}
                     : {1'b0, w[DATA_W-1:1]};
  endfunction

  assign in_ready   = !hold_full_q;
  assign accept     = in_valid && !hold_full_q;
  assign ser_out    = ser_out_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;

  bit_period_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (state_q != S_IDLE),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    ser_out_d    = ser_out_q;
    frame_done_d = 1'b0;
    load         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ser_out_d = IDLE_LINE;
        load      = hold_full_q;
      end
      S_START: begin
        if (bit_tick) begin
          state_d   = S_DATA;
          idx_d     = '0;
          ser_out_d = head(shift_q);
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          if (idx_q == LAST_IDX) begin
            state_d   = S_STOP;
            ser_out_d = STOP_BIT;
          end else begin
            idx_d     = idx_q + 1'b1;
            shift_d   = shift_next(shift_q);
            ser_out_d = head(shift_next(shift_q));
          end
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          frame_done_d = 1'b1;
          ser_out_d    = IDLE_LINE;
          load         = hold_full_q;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A held word starts its frame with no idle gap.
    if (load) begin
      state_d   = S_START;
      shift_d   = hold_q;
      ser_out_d = START_BIT;
    end
    hold_d      = accept ? in_data : hold_q;
    hold_full_d = accept ? 1'b1 : (load ? 1'b0 : hold_full_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hold_full_q  <= 1'b0;
      hold_q       <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      ser_out_q    <= IDLE_LINE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_full_q  <= hold_full_d;
      hold_q       <= hold_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      ser_out_q    <= ser_out_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: a frame-position model checks two
// instances every cycle, plus literal frame pattern checks.
module tb_serial_frame_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_v = 1'b0;
  logic b_v = 1'b0;
  logic [7:0] a_d = '0;
  logic [7:0] b_d = '0;
  logic a_rdy, a_ser, a_busy, a_done;
  logic b_rdy, b_ser, b_busy, b_done;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_frame_tx #(
    .DATA_W(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_v), .in_data(a_d), .in_ready(a_rdy),
    .ser_out(a_ser), .busy(a_busy), .frame_done(a_done)
  );

  serial_frame_tx #(
    .DATA_W(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_v), .in_data(b_d), .in_ready(b_rdy),
    .ser_out(b_ser), .busy(b_busy), .frame_done(b_done)
  );

  // Model: frame position in cycles (-1 = idle), word in flight,
  // one-entry hold. Frame = 10 symbols of CPB cycles each.
  int CPB[2] = '{4, 1};
  bit MSBF[2] = '{1'b0, 1'b1};
  int m_pos[2] = '{-1, -1};
  logic [7:0] m_cur[2];
  logic [7:0] m_hold[2];
  bit m_full[2] = '{1'b0, 1'b0};
  bit m_done[2] = '{1'b0, 1'b0};

  task automatic model_step(input int k, input bit v,
                            input logic [7:0] d);
    bit acc;
    if (rst) begin
      m_pos[k] = -1;
      m_full[k] = 1'b0;
      m_done[k] = 1'b0;
      return;
    end
    acc = v && !m_full[k];
    m_done[k] = (m_pos[k] == 10 * CPB[k] - 1);
    if (m_pos[k] >= 0) begin
      m_pos[k]++;
      if (m_pos[k] == 10 * CPB[k]) m_pos[k] = -1;
    end
    if (m_pos[k] < 0 && m_full[k]) begin
      m_cur[k] = m_hold[k];
      m_pos[k] = 0;
      m_full[k] = 1'b0;
    end
    if (acc) begin
      m_hold[k] = d;
      m_full[k] = 1'b1;
    end
  endtask

  function automatic logic exp_ser(input int k);
    int b;
    if (m_pos[k] < 0) return 1'b1;
    b = m_pos[k] / CPB[k];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return MSBF[k] ? m_cur[k][8-b] : m_cur[k][b-1];
  endfunction

  always @(posedge clk) begin
    model_step(0, a_v, a_d);
    model_step(1, b_v, b_d);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_ser", 32'(a_ser), 32'(exp_ser(0)));
      chk("a_rdy", 32'(a_rdy), 32'(!m_full[0]));
      chk("a_busy", 32'(a_busy), 32'(m_pos[0] >= 0));
      chk("a_done", 32'(a_done), 32'(m_done[0]));
      chk("b_ser", 32'(b_ser), 32'(exp_ser(1)));
      chk("b_rdy", 32'(b_rdy), 32'(!m_full[1]));
      chk("b_busy", 32'(b_busy), 32'(m_pos[1] >= 0));
      chk("b_done", 32'(b_done), 32'(m_done[1]));
    end
  end

  task automatic send(input bit sel, input logic [7:0] w);
    int n;
    n = 0;
    if (sel) begin b_v = 1'b1; b_d = w; end
    else begin a_v = 1'b1; a_d = w; end
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? b_rdy : a_rdy) && n < 500);
    chk("send_ready", 32'(sel ? b_rdy : a_rdy), 32'd1);
    @(posedge clk);
    #2;
    if (sel) b_v = 1'b0;
    else a_v = 1'b0;
  endtask

  // Waits for busy, then measures the busy run: its length, the
  // frame_done pulses, and the first 10 symbols at period c.
  task automatic run(input bit sel, input int c, output int len,
                     output int dones, output logic [9:0] sym);
    int w;
    len = 0;
    dones = 0;
    sym = '1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(sel ? b_busy : a_busy) && w < 200);
    if (!(sel ? b_busy : a_busy)) begin
      len = -1;
      return;
    end
    while ((sel ? b_busy : a_busy) && len < 2000) begin
      if (len % c == 0 && len / c < 10)
        sym[9 - len / c] = sel ? b_ser : a_ser;
      dones += int'(sel ? b_done : a_done);
      len++;
      @(negedge clk);
    end
    dones += int'(sel ? b_done : a_done);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_traffic(input bit sel);
    for (int i = 0; i < 25; i++) begin
      send(sel, 8'($urandom));
      repeat ($urandom_range(0, 60)) @(posedge clk);
      #2;
    end
  endtask

  int len, dn, w;
  logic [9:0] sym;

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    idle(20);
    chk("idle_ser", 32'(a_ser), 32'd1);
    chk("idle_rdy", 32'(a_rdy), 32'd1);
    chk("idle_busy", 32'(a_busy), 32'd0);
    chk("idle_done", 32'(a_done), 32'd0);
    @(posedge clk); #2;

    fork
      send(1'b0, 8'hA5);
      run(1'b0, 4, len, dn, sym);
    join
    chk("a5_sym", 32'(sym), 32'(10'b0101001011));
    chk("a5_len", 32'(len), 32'd40);
    chk("a5_done", 32'(dn), 32'd1);
    idle(5); @(posedge clk); #2;

    fork
      begin
        send(1'b0, 8'h3C);
        send(1'b0, 8'hC3);
        send(1'b0, 8'hFF);
      end
      run(1'b0, 4, len, dn, sym);
    join
    chk("b2b_sym", 32'(sym), 32'(10'b0001111001));
    chk("b2b_len", 32'(len), 32'd120);
    chk("b2b_done", 32'(dn), 32'd3);
    idle(5); @(posedge clk); #2;

    fork
      send(1'b1, 8'h81);
      run(1'b1, 1, len, dn, sym);
    join
    chk("msb_sym", 32'(sym), 32'(10'b0100000011));
    chk("msb_len", 32'(len), 32'd10);
    chk("msb_done", 32'(dn), 32'd1);
    idle(5); @(posedge clk); #2;

    send(1'b0, 8'h55);
    send(1'b0, 8'hAA);
    w = 0;
    while (m_pos[0] < 17 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("rst_reach", 32'(m_pos[0]), 32'd17);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ser", 32'(a_ser), 32'd1);
    chk("rst_rdy", 32'(a_rdy), 32'd1);
    chk("rst_busy", 32'(a_busy), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    len = 0;
    repeat (60) begin
      @(negedge clk);
      len += int'(a_busy);
    end
    chk("rst_nosend", 32'(len), 32'd0);
    @(posedge clk); #2;

    fork
      begin
        send(1'b0, 8'h10);
        w = 0;
        while (!a_busy && w < 200) begin
          @(negedge clk);
          w++;
        end
        repeat (36) @(negedge clk);
        @(posedge clk); #2;
        send(1'b0, 8'h0F);
      end
      run(1'b0, 4, len, dn, sym);
    join
    chk("stop_sym", 32'(sym), 32'(10'b0000010001));
    chk("stop_len", 32'(len), 32'd80);
    chk("stop_done", 32'(dn), 32'd2);
    idle(5); @(posedge clk); #2;

    fork
      rand_traffic(1'b0);
      rand_traffic(1'b1);
    join
    idle(60);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
